// File: rtl/ucsbece154a_mc_controller_if.sv
// Control bundle between the multicycle controller and the shared datapath.
// The controller is the master: it drives every control line and reads back the IR fields and zero.
interface ucsbece154a_mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       PCEn;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic       illegal;

    modport master (
        input  op, funct, zero,
        output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, illegal
    );

    modport slave (
        output op, funct, zero,
        input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, illegal
    );
endinterface

// File: rtl/ucsbece154a_mc_controller.sv
// Main control FSM for the multicycle MIPS core; memory states stretch by MEM_WAIT cycles.
// Define MC_BNE_EN to add bne support through the BRANCH state.
module ucsbece154a_mc_controller #(
    parameter int MEM_WAIT = 0
) (
    input  logic clk,
    input  logic reset,
    ucsbece154a_mc_controller_if.master ctrl
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       last_wait;
    logic       pc_write;
    logic       branch;
    logic       take_branch;
`ifdef MC_BNE_EN
    logic       bne_q;
`endif

    assign last_wait = (wait_cnt == WAIT_LAST);

    // State and wait counter; the counter only runs in the memory-access states.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            wait_cnt <= '0;
`ifdef MC_BNE_EN
            bne_q    <= 1'b0;
`endif
        end else begin
            wait_cnt <= '0;
            case (state)
                FETCH: begin
                    if (!last_wait) wait_cnt <= wait_cnt + 4'd1;
                    else            state    <= DECODE;
                end
                DECODE: begin
`ifdef MC_BNE_EN
                    bne_q <= (ctrl.op == OP_BNE);
`endif
                    case (ctrl.op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= EXECUTE;
                        OP_BEQ:       state <= BRANCH;
`ifdef MC_BNE_EN
                        OP_BNE:       state <= BRANCH;
`endif
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JUMP;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR:  state <= (ctrl.op == OP_SW) ? MEMWR : MEMRD;
                MEMRD: begin
                    if (!last_wait) wait_cnt <= wait_cnt + 4'd1;
                    else            state    <= MEMWB;
                end
                MEMWR: begin
                    if (!last_wait) wait_cnt <= wait_cnt + 4'd1;
                    else            state    <= FETCH;
                end
                EXECUTE: state <= ALUWB;
                ADDIEX:  state <= ADDIWB;
                default: state <= FETCH;
            endcase
        end
    end

    // Moore decode; under reset the FETCH values are shown with every strobe held low.
    always_comb begin
        ctrl.IorD       = 1'b0;
        ctrl.MemWrite   = 1'b0;
        ctrl.IRWrite    = 1'b0;
        ctrl.RegDst     = 1'b0;
        ctrl.MemtoReg   = 1'b0;
        ctrl.RegWrite   = 1'b0;
        ctrl.ALUSrcA    = 1'b0;
        ctrl.ALUSrcB    = 2'b00;
        ctrl.ALUControl = 3'b000;
        ctrl.PCSrc      = 2'b00;
        ctrl.illegal    = 1'b0;
        pc_write        = 1'b0;
        branch          = 1'b0;
        case (reset ? FETCH : state)
            FETCH: begin
                ctrl.ALUSrcB    = 2'b01;
                ctrl.ALUControl = 3'b010;
                ctrl.IRWrite    = last_wait;
                pc_write        = last_wait;
            end
            DECODE: begin
                ctrl.ALUSrcB    = 2'b11;
                ctrl.ALUControl = 3'b010;
                case (ctrl.op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ctrl.illegal = 1'b0;
`ifdef MC_BNE_EN
                    OP_BNE:  ctrl.illegal = 1'b0;
`endif
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            MEMADR, ADDIEX: begin
                ctrl.ALUSrcA    = 1'b1;
                ctrl.ALUSrcB    = 2'b10;
                ctrl.ALUControl = 3'b010;
            end
            MEMRD: ctrl.IorD = 1'b1;
            MEMWB: begin
                ctrl.MemtoReg = 1'b1;
                ctrl.RegWrite = 1'b1;
            end
            MEMWR: begin
                ctrl.IorD     = 1'b1;
                ctrl.MemWrite = last_wait;
            end
            EXECUTE: begin
                ctrl.ALUSrcA = 1'b1;
                case (ctrl.funct)
                    6'b100010: ctrl.ALUControl = 3'b110;
                    6'b100100: ctrl.ALUControl = 3'b000;
                    6'b100101: ctrl.ALUControl = 3'b001;
                    6'b101010: ctrl.ALUControl = 3'b111;
                    default:   ctrl.ALUControl = 3'b010;
                endcase
            end
            ALUWB: begin
                ctrl.RegDst   = 1'b1;
                ctrl.RegWrite = 1'b1;
            end
            BRANCH: begin
                ctrl.ALUSrcA    = 1'b1;
                ctrl.ALUControl = 3'b110;
                ctrl.PCSrc      = 2'b01;
                branch          = 1'b1;
            end
            ADDIWB: ctrl.RegWrite = 1'b1;
            JUMP: begin
                ctrl.PCSrc = 2'b10;
                pc_write   = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            ctrl.MemWrite = 1'b0;
            ctrl.IRWrite  = 1'b0;
            ctrl.RegWrite = 1'b0;
            ctrl.illegal  = 1'b0;
            pc_write      = 1'b0;
            branch        = 1'b0;
        end
    end

`ifdef MC_BNE_EN
    assign take_branch = bne_q ? ~ctrl.zero : ctrl.zero;
`else
    assign take_branch = ctrl.zero;
`endif

    assign ctrl.PCEn = pc_write | (branch & take_branch);

endmodule
